stack_pointer_unit: RTL and testbench

STACK_POINTER_UNIT -- requirements
Module: stack_pointer_unit

---
 rtl/stack_pkg.sv | 42 ++++
 rtl/stack_seq_fsm.sv | 58 +++++
 rtl/stack_pointer_unit.sv | 103 ++++++++++
 tb/tb_stack_pointer_unit.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the stack pointer unit: opcode encodings, per-op word
// counts, push/pop direction and default stack bounds.
package stack_pkg;

    localparam logic [31:0] SP_RESET_DEF    = 32'h000FFFFF;
    localparam logic [31:0] STACK_LIMIT_DEF = 32'h000FF000;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4,
        OP_INT  = 3'd5,
        OP_RTI  = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MULTI = 1'b1
    } seq_state_e;

    // Number of stack words an op touches; zero marks a no-op encoding.
    function automatic logic [1:0] op_words(input logic [2:0] op);
        case (op)
            OP_PUSH, OP_POP: op_words = 2'd1;
            OP_CALL, OP_RET: op_words = 2'd2;
            OP_INT,  OP_RTI: op_words = 2'd3;
            default:         op_words = 2'd0;
        endcase
    endfunction

    function automatic logic op_is_push(input logic [2:0] op);
        op_is_push = (op == OP_PUSH) || (op == OP_CALL) || (op == OP_INT);
    endfunction

    function automatic logic op_is_real(input logic [2:0] op);
        op_is_real = (op_words(op) != 2'd0);
    endfunction

endpackage

// File: rtl/stack_seq_fsm.sv
// Word sequencer: walks multi-word stack ops one word per running cycle and
// tells the datapath which op/word is being attempted.
module stack_seq_fsm
    import stack_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       op_valid,
    input  logic [2:0] op_code,
    input  logic       blocked,
    output logic       attempt,
    output logic [2:0] cur_op,
    output logic [1:0] cur_idx,
    output logic       busy
);

    seq_state_e state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [1:0] idx_q, idx_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= 3'd0;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
        end
    end

    // A blocked word aborts the whole op, as does issuing its last word.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        idx_d   = idx_q;
        if (attempt) begin
            if (blocked || (cur_idx == op_words(cur_op) - 2'd1)) begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
            end else begin
                state_d = ST_MULTI;
                op_d    = cur_op;
                idx_d   = cur_idx + 2'd1;
            end
        end
    end

    always_comb begin
        busy    = (state_q == ST_MULTI);
        cur_op  = busy ? op_q : op_code;
        cur_idx = busy ? idx_q : 2'd0;
        attempt = run && (busy || (op_valid && op_is_real(op_code)));
    end

endmodule

// File: rtl/stack_pointer_unit.sv
// Stack pointer datapath: post-decrement pushes, pre-increment pops, bounds
// checking with sticky fault flags, and a registered per-word address output.
module stack_pointer_unit
    import stack_pkg::*;
#(
    parameter logic [31:0] SP_RESET    = SP_RESET_DEF,
    parameter logic [31:0] STACK_LIMIT = STACK_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        stall_in,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    output logic [31:0] SP_VALUE,
    output logic        Stack_OP,
    output logic [1:0]  word_idx,
    output logic        busy,
    output logic        overflow,
    output logic        underflow
);

    logic        run;
    logic        attempt;
    logic        blocked;
    logic        is_push;
    logic [2:0]  cur_op;
    logic [1:0]  cur_idx;

    logic [31:0] sp_q, sp_d;
    logic [31:0] sp_value_q, sp_value_d;
    logic        stack_op_q, stack_op_d;
    logic [1:0]  word_idx_q, word_idx_d;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;

    assign run     = enable && !stall_in;
    assign is_push = op_is_push(cur_op);
    assign blocked = attempt && (is_push ? (sp_q < STACK_LIMIT) : (sp_q >= SP_RESET));

    stack_seq_fsm u_seq (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .op_valid (op_valid),
        .op_code  (op_code),
        .blocked  (blocked),
        .attempt  (attempt),
        .cur_op   (cur_op),
        .cur_idx  (cur_idx),
        .busy     (busy)
    );

    always_comb begin
        sp_d        = sp_q;
        sp_value_d  = sp_value_q;
        stack_op_d  = 1'b0;
        word_idx_d  = word_idx_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (attempt) begin
            if (blocked) begin
                if (is_push) overflow_d  = 1'b1;
                else         underflow_d = 1'b1;
            end else begin
                stack_op_d = 1'b1;
                word_idx_d = cur_idx;
                if (is_push) begin
                    sp_value_d = sp_q;
                    sp_d       = sp_q - 32'd1;
                end else begin
                    sp_value_d = sp_q + 32'd1;
                    sp_d       = sp_q + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q        <= SP_RESET;
            sp_value_q  <= 32'd0;
            stack_op_q  <= 1'b0;
            word_idx_q  <= 2'd0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            sp_value_q  <= sp_value_d;
            stack_op_q  <= stack_op_d;
            word_idx_q  <= word_idx_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign SP_VALUE  = sp_value_q;
    assign Stack_OP  = stack_op_q;
    assign word_idx  = word_idx_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Directed bench for stack_pointer_unit with a queue of expected per-cycle results.
module tb_stack_pointer_unit;
    import stack_pkg::*;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        stall_in;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] SP_VALUE;
    logic        Stack_OP;
    logic [1:0]  word_idx;
    logic        busy;
    logic        overflow;
    logic        underflow;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [31:0] sv;
        logic        sop;
        logic [1:0]  idx;
        logic        bsy;
        logic        ovf;
        logic        udf;
        logic [31:0] sp;
    } exp_t;

    exp_t exp_q[$];

    stack_pointer_unit dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .stall_in  (stall_in),
        .op_valid  (op_valid),
        .op_code   (op_code),
        .SP_VALUE  (SP_VALUE),
        .Stack_OP  (Stack_OP),
        .word_idx  (word_idx),
        .busy      (busy),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input string field, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, expv);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] sv, input logic sop, input logic [1:0] idx,
                            input logic bsy, input logic ovf, input logic udf, input logic [31:0] sp);
        exp_t e;
        e.tag = tag; e.sv = sv; e.sop = sop; e.idx = idx;
        e.bsy = bsy; e.ovf = ovf; e.udf = udf; e.sp = sp;
        exp_q.push_back(e);
    endtask

    task automatic pop_and_check();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = exp_q.pop_front();
        chk(e.tag, "SP_VALUE",  SP_VALUE,          e.sv);
        chk(e.tag, "Stack_OP",  {31'd0, Stack_OP},  {31'd0, e.sop});
        chk(e.tag, "word_idx",  {30'd0, word_idx},  {30'd0, e.idx});
        chk(e.tag, "busy",      {31'd0, busy},      {31'd0, e.bsy});
        chk(e.tag, "overflow",  {31'd0, overflow},  {31'd0, e.ovf});
        chk(e.tag, "underflow", {31'd0, underflow}, {31'd0, e.udf});
        chk(e.tag, "sp",        dut.sp_q,           e.sp);
        $display("step %-12s SP_VALUE=%h Stack_OP=%0d idx=%0d busy=%0d ovf=%0d udf=%0d sp=%h",
                 e.tag, SP_VALUE, Stack_OP, word_idx, busy, overflow, underflow, dut.sp_q);
    endtask

    // Drive one cycle of stimulus, record what should appear after the edge, then compare.
    task automatic step(input string tag, input logic v, input logic [2:0] opc, input logic stl, input logic en,
                        input logic [31:0] sv, input logic sop, input logic [1:0] idx,
                        input logic bsy, input logic ovf, input logic udf, input logic [31:0] sp);
        op_valid = v;
        op_code  = opc;
        stall_in = stl;
        enable   = en;
        push_exp(tag, sv, sop, idx, bsy, ovf, udf, sp);
        @(posedge clk);
        #1;
        pop_and_check();
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; stall_in = 1'b0; op_valid = 1'b0; op_code = OP_NOP;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        push_exp("reset", 32'h0, 0, 0, 0, 0, 0, 32'h000FFFFF);
        #1 pop_and_check();

        //    tag          v  op       stl en  SP_VALUE       sop idx bsy ovf udf sp
        step("push",       1, OP_PUSH, 0, 1, 32'h000FFFFF, 1, 0, 0, 0, 0, 32'h000FFFFE);
        step("idle",       0, OP_NOP,  0, 1, 32'h000FFFFF, 0, 0, 0, 0, 0, 32'h000FFFFE);
        step("pop",        1, OP_POP,  0, 1, 32'h000FFFFF, 1, 0, 0, 0, 0, 32'h000FFFFF);
        step("int_w0",     1, OP_INT,  0, 1, 32'h000FFFFF, 1, 0, 1, 0, 0, 32'h000FFFFE);
        step("int_w1",     1, OP_POP,  0, 1, 32'h000FFFFE, 1, 1, 1, 0, 0, 32'h000FFFFD);
        step("int_w2",     1, OP_POP,  0, 1, 32'h000FFFFD, 1, 2, 0, 0, 0, 32'h000FFFFC);
        step("rti_w0",     1, OP_RTI,  0, 1, 32'h000FFFFD, 1, 0, 1, 0, 0, 32'h000FFFFD);
        step("rti_w1",     0, OP_NOP,  0, 1, 32'h000FFFFE, 1, 1, 1, 0, 0, 32'h000FFFFE);
        step("rti_w2",     0, OP_NOP,  0, 1, 32'h000FFFFF, 1, 2, 0, 0, 0, 32'h000FFFFF);
        step("call_w0",    1, OP_CALL, 0, 1, 32'h000FFFFF, 1, 0, 1, 0, 0, 32'h000FFFFE);
        step("call_stl1",  1, OP_CALL, 1, 1, 32'h000FFFFF, 0, 0, 1, 0, 0, 32'h000FFFFE);
        step("call_stl2",  1, OP_CALL, 1, 1, 32'h000FFFFF, 0, 0, 1, 0, 0, 32'h000FFFFE);
        step("call_dis",   1, OP_CALL, 0, 0, 32'h000FFFFF, 0, 0, 1, 0, 0, 32'h000FFFFE);
        step("call_w1",    0, OP_NOP,  0, 1, 32'h000FFFFE, 1, 1, 0, 0, 0, 32'h000FFFFD);
        step("ret_w0",     1, OP_RET,  0, 1, 32'h000FFFFE, 1, 0, 1, 0, 0, 32'h000FFFFE);
        step("ret_w1",     0, OP_NOP,  0, 1, 32'h000FFFFF, 1, 1, 0, 0, 0, 32'h000FFFFF);
        step("op7",        1, OP_RSVD, 0, 1, 32'h000FFFFF, 0, 1, 0, 0, 0, 32'h000FFFFF);
        step("push_dis",   1, OP_PUSH, 0, 0, 32'h000FFFFF, 0, 1, 0, 0, 0, 32'h000FFFFF);
        step("pop_under",  1, OP_POP,  0, 1, 32'h000FFFFF, 0, 1, 0, 0, 1, 32'h000FFFFF);
        step("udf_push",   1, OP_PUSH, 0, 1, 32'h000FFFFF, 1, 0, 0, 0, 1, 32'h000FFFFE);
        step("int2_w0",    1, OP_INT,  0, 1, 32'h000FFFFE, 1, 0, 1, 0, 1, 32'h000FFFFD);
        step("int2_w1",    0, OP_NOP,  0, 1, 32'h000FFFFD, 1, 1, 1, 0, 1, 32'h000FFFFC);

        // Asynchronous reset in the middle of the INT, before word 2 issues.
        #1 rst = 1'b1;
        push_exp("rst_mid", 32'h0, 0, 0, 0, 0, 0, 32'h000FFFFF);
        #1 pop_and_check();
        @(posedge clk); #1;
        rst = 1'b0;
        step("post_rst",   1, OP_INT,  1, 1, 32'h0,        0, 0, 0, 0, 0, 32'h000FFFFF);

        // Fill the stack down to STACK_LIMIT, then one more push must fault.
        for (int i = 0; i < 4096; i++) begin
            step("push_fill", 1, OP_PUSH, 0, 1, 32'h000FFFFF - i, 1, 0, 0, 0, 0, 32'h000FFFFE - i);
        end
        step("push_over",  1, OP_PUSH, 0, 1, 32'h000FF000, 0, 0, 0, 1, 0, 32'h000FEFFF);
        step("ovf_hold",   0, OP_NOP,  0, 1, 32'h000FF000, 0, 0, 0, 1, 0, 32'h000FEFFF);
        step("pop_limit",  1, OP_POP,  0, 1, 32'h000FF000, 1, 0, 0, 1, 0, 32'h000FF000);
        step("int3_w0",    1, OP_INT,  0, 1, 32'h000FF000, 1, 0, 1, 1, 0, 32'h000FEFFF);
        step("int3_abort", 0, OP_NOP,  0, 1, 32'h000FF000, 0, 0, 0, 1, 0, 32'h000FEFFF);
        step("abort_idle", 0, OP_NOP,  0, 1, 32'h000FF000, 0, 0, 0, 1, 0, 32'h000FEFFF);

        #1 rst = 1'b1;
        push_exp("rst_flags", 32'h0, 0, 0, 0, 0, 0, 32'h000FFFFF);
        #1 pop_and_check();
        @(posedge clk); #1;
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
